// File: rtl/apb_slave_mem_pkg.sv
// Shared APB encodings and the completer FSM state type.
// Imported by the apb_slave_mem block and its bridge-side peers.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } slv_state_e;

  localparam logic READY     = 1'b1;
  localparam logic NOT_READY = 1'b0;
  localparam logic ERROR     = 1'b1;
  localparam logic NO_ERROR  = 1'b0;
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE_  = 1'b0;
  localparam logic READ      = 1'b0;
  localparam logic WRITE     = 1'b1;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB slot bundle: PSEL/PENABLE/PWRITE/PADDR/PWDATA from the bridge,
// PRDATA/PREADY/PSLVERR back from the completer.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_WIDTH word store, sync reset, 1 write port
// (i_we/i_wr_idx/i_wr_data) and 1 combinational read port.
module apb_slave_regfile #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IW         = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [IW-1:0]         i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a word window, programmable wait states and PSLVERR.
// Ports: HCLK, HRESET, bus (slave modport), WAIT_CFG in, ERR_CNT out.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h100,
  parameter int                  DEPTH      = 64,
  parameter int                  RO_WORDS   = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  apb_slave_mem_if.slave bus,
  input  logic [3:0]  WAIT_CFG,
  output logic [7:0]  ERR_CNT
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  slv_state_e            r_state, w_state_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic                  r_write, w_write_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_err, w_err_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nxt;
  logic                  r_pready, w_pready_nxt;
  logic                  r_pslverr, w_pslverr_nxt;
  logic [7:0]            r_err_cnt, w_err_cnt_nxt;

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_idx_full;
  logic [IW-1:0]         w_idx;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_we;
  logic [IW-1:0]         w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Offset wraps when PADDR is below the base; the explicit
  // compare catches that case too.
  assign w_off      = bus.PADDR - BASE_ADDR;
  assign w_idx_full = {2'b00, w_off[ADDR_WIDTH-1:2]};
  assign w_idx      = w_idx_full[IW-1:0];
  assign w_err      = (bus.PADDR < BASE_ADDR)
                   || (w_off[1:0] != 2'b00)
                   || (w_idx_full >= ADDR_WIDTH'(DEPTH))
                   || (bus.PWRITE == WRITE
                       && w_idx_full < ADDR_WIDTH'(RO_WORDS));
  assign w_setup    = bus.PSEL && (bus.PENABLE == DISABLE_);

  apb_slave_regfile #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IW         (IW)
  ) u_regfile (
    .clk       (HCLK),
    .rst       (HRESET),
    .i_we      (w_we),
    .i_wr_idx  (r_idx),
    .i_wr_data (r_wdata),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_write_nxt   = r_write;
    w_wdata_nxt   = r_wdata;
    w_err_nxt     = r_err;
    w_cnt_nxt     = r_cnt;
    w_prdata_nxt  = r_prdata;
    w_pready_nxt  = r_pready;
    w_pslverr_nxt = r_pslverr;
    w_err_cnt_nxt = r_err_cnt;
    w_we          = 1'b0;
    w_rd_idx      = r_idx;

    unique case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        // Zero-wait reads fetch straight from the live address.
        w_rd_idx    = w_idx;
        if (w_setup) begin
          w_state_nxt = ACCESS;
          w_idx_nxt   = w_idx;
          w_write_nxt = bus.PWRITE;
          w_wdata_nxt = bus.PWDATA;
          w_err_nxt   = w_err;
          w_cnt_nxt   = WAIT_CFG;
          if (WAIT_CFG == 4'd0) begin
            w_pready_nxt  = READY;
            w_pslverr_nxt = w_err;
            if (!w_err && bus.PWRITE == READ)
              w_prdata_nxt = w_rd_data;
          end
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          w_state_nxt   = IDLE;
          w_pready_nxt  = NOT_READY;
          w_pslverr_nxt = NO_ERROR;
        end else if (r_pready == NOT_READY) begin
          if (r_cnt > 4'd1) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_cnt_nxt     = 4'd0;
            w_pready_nxt  = READY;
            w_pslverr_nxt = r_err;
            if (!r_err && r_write == READ)
              w_prdata_nxt = w_rd_data;
          end
        end else if (bus.PENABLE == ENABLE) begin
          w_we = (r_write == WRITE) && !r_err;
          if (r_err && r_write == READ)
            w_prdata_nxt = '0;
          if (r_pslverr && r_err_cnt != 8'hFF)
            w_err_cnt_nxt = r_err_cnt + 8'd1;
          w_pready_nxt  = NOT_READY;
          w_pslverr_nxt = NO_ERROR;
          w_state_nxt   = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_write   <= READ;
      r_wdata   <= '0;
      r_err     <= NO_ERROR;
      r_cnt     <= '0;
      r_prdata  <= '0;
      r_pready  <= NOT_READY;
      r_pslverr <= NO_ERROR;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_write   <= w_write_nxt;
      r_wdata   <= w_wdata_nxt;
      r_err     <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign bus.PRDATA  = r_prdata;
  assign bus.PREADY  = r_pready;
  assign bus.PSLVERR = r_pslverr;
  assign ERR_CNT     = r_err_cnt;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: transfers, waits, errors,
// back-to-back, abort, reset and error-counter saturation.
module tb_apb_slave_mem;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] WAIT_CFG;
  logic [7:0] ERR_CNT;

  int n_chk  = 0;
  int n_fail = 0;

  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_slave_mem dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .bus      (bus),
    .WAIT_CFG (WAIT_CFG),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (!HRESET) begin
      n_chk++;
      if (bus.PSLVERR && !bus.PREADY) begin
        n_fail++;
        $display("FAIL slverr_wo_ready at %0t", $time);
      end
    end
  end

  task automatic setup(input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] w);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    WAIT_CFG    = w;
  endtask

  task automatic idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  // Enters the access phase and returns at the negedge where PREADY
  // is seen, leaving the access phase driven for the completing edge.
  task automatic wait_ready(input logic scramble, output int waits,
                            output logic [31:0] rd, output logic er,
                            output logic [31:0] p0);
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    if (scramble) begin
      bus.PADDR  = 32'h100;
      bus.PWDATA = 32'h0;
      bus.PWRITE = ~bus.PWRITE;
      WAIT_CFG   = 4'd0;
    end
    p0    = bus.PRDATA;
    waits = 0;
    while (!bus.PREADY && waits < 40) begin
      @(negedge HCLK);
      waits++;
    end
    if (waits >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout got no PREADY want PREADY");
    end
    rd = bus.PRDATA;
    er = bus.PSLVERR;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] w,
                      output int waits, output logic [31:0] rd,
                      output logic er);
    logic [31:0] p0;
    @(negedge HCLK);
    setup(wr, a, d, w);
    wait_ready(1'b0, waits, rd, er, p0);
    @(negedge HCLK);
    idle();
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    idle();
    bus.PWRITE = 1'b0;
    bus.PADDR  = '0;
    bus.PWDATA = '0;
    WAIT_CFG   = '0;
    repeat (3) @(negedge HCLK);
    n_chk++;
    if (bus.PRDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_prdata got %h want 0", bus.PRDATA);
    end
    n_chk++;
    if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready got %b%b want 00",
               bus.PREADY, bus.PSLVERR);
    end
    n_chk++;
    if (ERR_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_errcnt got %0d want 0", ERR_CNT);
    end
    HRESET = 1'b0;
  endtask

  task automatic test_zero_wait();
    int w;
    logic [31:0] rd;
    logic er;
    xfer(1'b1, 32'h110, 32'hDEADBEEF, 4'd0, w, rd, er);
    n_chk++;
    if (w !== 0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_write got w=%0d e=%b want w=0 e=0", w, er);
    end
    xfer(1'b0, 32'h110, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (w !== 0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_read got w=%0d e=%b want w=0 e=0", w, er);
    end
    n_chk++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL zw_rdata got %h want deadbeef", rd);
    end
    n_chk++;
    if (ERR_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL zw_errcnt got %0d want 0", ERR_CNT);
    end
  endtask

  task automatic test_wait_states();
    int w;
    logic [31:0] rd, p0;
    logic er;
    xfer(1'b1, 32'h110, 32'h0BADF00D, 4'd3, w, rd, er);
    n_chk++;
    if (w !== 3 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL ws_write got w=%0d e=%b want w=3 e=0", w, er);
    end
    @(negedge HCLK);
    setup(1'b0, 32'h110, 32'h0, 4'd3);
    wait_ready(1'b0, w, rd, er, p0);
    @(negedge HCLK);
    idle();
    n_chk++;
    if (w !== 3) begin
      n_fail++;
      $display("FAIL ws_read_waits got %0d want 3", w);
    end
    n_chk++;
    if (p0 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ws_early_rdata got %h want deadbeef", p0);
    end
    n_chk++;
    if (rd !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL ws_rdata got %h want 0badf00d", rd);
    end
  endtask

  task automatic test_errors();
    int w;
    logic [31:0] rd;
    logic er;
    xfer(1'b1, 32'h104, 32'h12345678, 4'd0, w, rd, er);
    n_chk++;
    if (er !== 1'b1 || ERR_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL err_ro_wr got e=%b c=%0d want e=1 c=1", er, ERR_CNT);
    end
    xfer(1'b0, 32'h104, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_ro_rd got e=%b d=%h want e=0 d=0", er, rd);
    end
    xfer(1'b0, 32'h110, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (rd !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL err_pre_rd got %h want 0badf00d", rd);
    end
    xfer(1'b0, 32'h112, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (er !== 1'b1 || bus.PRDATA !== 32'h0 || ERR_CNT !== 8'd2) begin
      n_fail++;
      $display("FAIL err_misalign got e=%b d=%h c=%0d want e=1 d=0 c=2",
               er, bus.PRDATA, ERR_CNT);
    end
    xfer(1'b0, 32'h200, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (er !== 1'b1 || ERR_CNT !== 8'd3) begin
      n_fail++;
      $display("FAIL err_range got e=%b c=%0d want e=1 c=3", er, ERR_CNT);
    end
    xfer(1'b0, 32'h0FC, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (er !== 1'b1 || ERR_CNT !== 8'd4) begin
      n_fail++;
      $display("FAIL err_below got e=%b c=%0d want e=1 c=4", er, ERR_CNT);
    end
    xfer(1'b0, 32'h1FC, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (er !== 1'b0 || rd !== 32'h0 || ERR_CNT !== 8'd4) begin
      n_fail++;
      $display("FAIL err_last got e=%b d=%h c=%0d want e=0 d=0 c=4",
               er, rd, ERR_CNT);
    end
    xfer(1'b1, 32'h10C, 32'h5, 4'd2, w, rd, er);
    n_chk++;
    if (er !== 1'b1 || w !== 2 || ERR_CNT !== 8'd5) begin
      n_fail++;
      $display("FAIL err_ro3 got e=%b w=%0d c=%0d want e=1 w=2 c=5",
               er, w, ERR_CNT);
    end
  endtask

  task automatic test_protocol_ignore();
    @(negedge HCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 32'h110;
    WAIT_CFG    = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      n_chk++;
      if (bus.PREADY !== 1'b0) begin
        n_fail++;
        $display("FAIL proto_ignore got %b want 0", bus.PREADY);
      end
    end
    idle();
  endtask

  task automatic test_midchange();
    int w;
    logic [31:0] rd, p0;
    logic er;
    @(negedge HCLK);
    setup(1'b1, 32'h114, 32'h77, 4'd2);
    wait_ready(1'b1, w, rd, er, p0);
    @(negedge HCLK);
    idle();
    n_chk++;
    if (w !== 2 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wr got w=%0d e=%b want w=2 e=0", w, er);
    end
    xfer(1'b0, 32'h114, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (rd !== 32'h77) begin
      n_fail++;
      $display("FAIL mid_rd got %h want 77", rd);
    end
    xfer(1'b0, 32'h100, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_word0 got %h want 0", rd);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] rd, p0;
    logic er;
    @(negedge HCLK);
    setup(1'b1, 32'h120, 32'h1, 4'd0);
    wait_ready(1'b0, w, rd, er, p0);
    n_chk++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL b2b_wr got w=%0d want 0", w);
    end
    @(negedge HCLK);
    setup(1'b0, 32'h120, 32'h0, 4'd0);
    wait_ready(1'b0, w, rd, er, p0);
    @(negedge HCLK);
    idle();
    n_chk++;
    if (w !== 0 || rd !== 32'h1) begin
      n_fail++;
      $display("FAIL b2b_rd got w=%0d d=%h want w=0 d=1", w, rd);
    end
  endtask

  task automatic test_abort();
    int w;
    logic [31:0] rd;
    logic er;
    @(negedge HCLK);
    setup(1'b1, 32'h130, 32'hAAAA5555, 4'd5);
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (bus.PREADY !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_wait got %b want 0", bus.PREADY);
      end
      if (i == 0) @(negedge HCLK);
    end
    idle();
    repeat (2) @(negedge HCLK);
    n_chk++;
    if (bus.PREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready got %b want 0", bus.PREADY);
    end
    xfer(1'b0, 32'h130, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (w !== 0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_rd got w=%0d d=%h want w=0 d=0", w, rd);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [31:0] rd;
    logic er;
    xfer(1'b0, 32'h110, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (rd !== 32'h0BADF00D || ERR_CNT !== 8'd5) begin
      n_fail++;
      $display("FAIL rm_pre got d=%h c=%0d want 0badf00d c=5", rd, ERR_CNT);
    end
    @(negedge HCLK);
    setup(1'b1, 32'h130, 32'h55, 4'd5);
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    n_chk++;
    if (bus.PRDATA !== 32'h0 || bus.PREADY !== 1'b0 ||
        bus.PSLVERR !== 1'b0 || ERR_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL rm_outs got d=%h r=%b e=%b c=%0d want all 0",
               bus.PRDATA, bus.PREADY, bus.PSLVERR, ERR_CNT);
    end
    HRESET = 1'b0;
    idle();
    xfer(1'b0, 32'h130, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_mem130 got %h want 0", rd);
    end
    xfer(1'b0, 32'h110, 32'h0, 4'd0, w, rd, er);
    n_chk++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_mem110 got %h want 0", rd);
    end
  endtask

  task automatic test_saturation();
    int w;
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 260; i++) begin
      xfer(1'b0, 32'h200, 32'h0, 4'd0, w, rd, er);
      n_chk++;
      if (er !== 1'b1 || w !== 0) begin
        n_fail++;
        $display("FAIL sat_resp %0d got e=%b w=%0d want e=1 w=0", i, er, w);
      end
      if (i == 254) begin
        n_chk++;
        if (ERR_CNT !== 8'd255) begin
          n_fail++;
          $display("FAIL sat_255 got %0d want 255", ERR_CNT);
        end
      end
    end
    n_chk++;
    if (ERR_CNT !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final got %0d want 255", ERR_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_protocol_ignore();
    test_midchange();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_saturation();
    @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB responder (completer) for one slave slot behind the AHB-to-APB bridge.
- Holds a word-addressed register/memory window and answers read and write transfers.
- Inserts programmable wait states through PREADY and signals PSLVERR for illegal accesses.
- One instance per PSELx bit. PRDATA, PREADY and PSLVERR feed that slot's lane of the bridge's per-slave response vectors.

Parameters:
- ADDR_WIDTH, 32, width of PADDR.
- DATA_WIDTH, 32, width of PWDATA/PRDATA.
- BASE_ADDR, 32'h100, byte address of word 0 of this slave's window.
- DEPTH, 64, number of DATA_WIDTH words; must be at most 2^(ADDR_WIDTH-2).
- RO_WORDS, 4, words 0..RO_WORDS-1 are read-only.

Ports:
- HCLK  in  1  clock, shared with the bridge.
- HRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  this slave's PSELx bit.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- WAIT_CFG  in  4  wait states per transfer; sampled in the setup cycle.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error for the completing transfer.
- ERR_CNT  out  8  saturating count of error responses.

Behaviour:
- Clock and reset:
  - One clock, HCLK. Reset HRESET is synchronous and active-high.
  - On reset: PRDATA=0, PREADY=0, PSLVERR=0, ERR_CNT=0, state=IDLE, all memory words=0, wait counter=0.
- Address decode:
  - off = PADDR - BASE_ADDR (ADDR_WIDTH bits, unsigned); idx = off >> 2.
  - err_addr = PADDR < BASE_ADDR, or off[1:0] != 0, or idx >= DEPTH.
  - err = err_addr, or (PWRITE and idx < RO_WORDS).
- FSM states (in shared package): IDLE, ACCESS, DONE.
- IDLE:
  - On a rising edge sampling PSEL=1 and PENABLE=0 (setup): latch idx, PWRITE, PWDATA, err; load cnt=WAIT_CFG; go to ACCESS.
  - If WAIT_CFG==0, also set PREADY<=1 and PSLVERR<=err in the same edge, and load PRDATA<=mem[idx] for a legal read. This makes a zero-wait transfer complete in the first access cycle.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol error. Ignore it: no response, stay in IDLE.
- ACCESS:
  - If PSEL=0: abort. Clear PREADY and PSLVERR, no memory update, go to IDLE.
  - If PREADY=0 and cnt>1: cnt<=cnt-1.
  - If PREADY=0 and cnt==1: cnt<=0, PREADY<=1, PSLVERR<=err, PRDATA<=mem[idx] for a legal read.
  - If PREADY=1 and PSEL and PENABLE sampled high: the transfer completes.
    - Legal write: mem[idx]<=wdata.
    - Erroring write: no update.
    - Erroring read: PRDATA is forced to 0.
    - If PSLVERR, ERR_CNT increments, saturating at 255.
    - Clear PREADY and PSLVERR; go to DONE.
- Latency: a read or write completes WAIT_CFG+1 cycles after the setup cycle; minimum 2-cycle APB transfer.
- DONE:
  - Single cycle that returns to IDLE.
  - A setup seen in this cycle (back-to-back transfer) is handled exactly as in IDLE, so back-to-back transfers lose no cycles.
  - PRDATA holds its last value until the next read completes.
- PREADY and PSLVERR are high only in completing cycles. PSLVERR is never high while PREADY is low, because the bridge samples PSLVERR every cycle.
- Mid-transfer changes: changes to PADDR, PWRITE, PWDATA or WAIT_CFG during the access phase are ignored; the setup-cycle values are used.
- Reset mid-transfer: reset wins. No write commits, and the outputs take their reset values on that edge.

Decomposition:
- Shared package apb_pkg holds:
  - the slave FSM state enum;
  - constants READY/NOT_READY, ERROR/NO_ERROR, ENABLE/DISABLE_, READ/WRITE, matching the bridge's encodings.
- One sub-module, apb_slave_regfile: DEPTH x DATA_WIDTH storage with synchronous reset, one write port (we, idx, data) and one combinational read port.
- The FSM, decode and error logic stay in apb_slave_mem.

Test Plan:
- Zero-wait write then read: WAIT_CFG=0, write 0xDEADBEEF to 0x110, then read 0x110 -> PREADY high in the first access cycle of each; PRDATA=0xDEADBEEF; PSLVERR=0; ERR_CNT=0.
- Wait states: WAIT_CFG=3, read 0x110 -> PREADY low for 3 access cycles and high on the 4th; PRDATA valid only in that cycle or later.
- Errors:
  - Write 0x12345678 to 0x104 (RO word 1) -> PSLVERR=1 with PREADY, mem[1] stays 0, ERR_CNT=1.
  - Read 0x112 (misaligned) -> PSLVERR=1, PRDATA=0, ERR_CNT=2.
  - Read 0x200 (idx 64 >= DEPTH) -> PSLVERR=1, ERR_CNT=3.
- Back-to-back: write 0x1 to 0x120, then immediately a setup to read 0x120 on the cycle after completion -> the read returns 0x1 with no idle gap.
- Abort and reset:
  - WAIT_CFG=5 write to 0x130, drop PSEL after 2 access cycles -> no update (read of 0x130 = 0), state returns to IDLE.
  - Assert HRESET mid-wait -> all outputs 0 next cycle, mem[0x130 idx]=0.
- Saturation: 260 erroring accesses -> ERR_CNT stops at 255; PREADY still asserted for each.
